// File: rtl/chip8_kbd_pkg.sv
// Shared definitions for the CHIP-8 hex keypad scanner.
// Contents:
//   KEY_IDLE      event byte presented when no event is pending
//   EV_PRESS_BIT  bit of the event byte that carries pressed(1)/released(0)
//   KEYMAP        physical matrix index (row*4+col) -> CHIP-8 key code
//   scan_state_t  scanner FSM states
//   pack_event()  builds an event byte from level and key code
package chip8_kbd_pkg;

    localparam logic [7:0]  KEY_IDLE     = 8'hFF;
    localparam int unsigned EV_PRESS_BIT = 7;

    // Physical layout, row-major:
    //   row0: 1 2 3 C   row1: 4 5 6 D   row2: 7 8 9 E   row3: A 0 B F
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };

    typedef enum logic {
        DRIVE  = 1'b0,
        UPDATE = 1'b1
    } scan_state_t;

    function automatic logic [7:0] pack_event(input logic pressed, input logic [3:0] key);
        logic [7:0] ev;
        ev               = '0;
        ev[EV_PRESS_BIT] = pressed;
        ev[3:0]          = key;
        return ev;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Synchronous FIFO for 8-bit key-event bytes.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_din    write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   o_full           all FIFO_DEPTH entries occupied
//   i_pop            read request; ignored when empty
//   o_empty          no entries
//   o_dout           head entry, KEY_IDLE when empty
module keypad_event_fifo
    import chip8_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic [7:0] i_din,
    output logic       o_full,
    input  logic       i_pop,
    output logic       o_empty,
    output logic [7:0] o_dout
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_pop;
    logic        w_push;

    // Extra pointer MSB distinguishes full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = i_pop & ~o_empty;
    // When full, a simultaneous pop frees the head slot, which is the one written.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_dout  = o_empty ? KEY_IDLE : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 CHIP-8 keypad matrix scanner with per-key debounce and event FIFO.
// Ports:
//   clk_in       system clock
//   rst_n_in     synchronous active-low reset
//   col_out      column drive, active-low, at most one column low
//   row_in       row sense, active-low, asynchronous (synchronized here)
//   event_valid  event byte available
//   event_data   {level, 3'b000, key}; 8'hFF when no event
//   event_ready  consumer accepts the head byte
//   key_state    debounced level per CHIP-8 key
//   overflow     sticky: an event was dropped on a full FIFO
module keypad_scanner
    import chip8_kbd_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,  // >= 3
    parameter int unsigned DEBOUNCE_SCANS = 3,  // 1..15
    parameter int unsigned FIFO_DEPTH     = 8   // power of two, >= 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic [3:0]  col_out,
    input  logic [3:0]  row_in,
    output logic        event_valid,
    output logic [7:0]  event_data,
    input  logic        event_ready,
    output logic [15:0] key_state,
    output logic        overflow
);

    localparam int unsigned DW = $clog2(SCAN_DIV);

    scan_state_t r_state;
    logic [DW-1:0] r_div;
    logic [1:0]    r_col;
    logic [1:0]    r_row;
    logic [3:0]    r_row_s1;
    logic [3:0]    r_row_s2;
    logic [3:0]    r_raw;
    logic [3:0]    r_cnt [16];
    logic [15:0]   r_key_state;
    logic [3:0]    r_col_out;
    logic          r_overflow;

    logic [3:0] w_p;
    logic [3:0] w_k;
    logic       w_level;
    logic       w_sample;
    logic [3:0] w_cnt_next;
    logic       w_flip;
    logic [1:0] w_col_next;
    logic [7:0] w_event;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_drop;

    assign w_p        = {r_row, r_col};
    assign w_k        = KEYMAP[w_p];
    assign w_level    = r_key_state[w_k];
    assign w_sample   = r_raw[r_row];
    assign w_cnt_next = r_cnt[w_p] + 4'd1;
    assign w_flip     = (r_state == UPDATE) && (w_sample != w_level) &&
                        (w_cnt_next == 4'(DEBOUNCE_SCANS));
    assign w_event    = pack_event(~w_level, w_k);
    assign w_col_next = ((r_state == UPDATE) && (r_row == 2'd3)) ? r_col + 2'd1 : r_col;
    assign w_pop      = event_ready & ~w_empty;
    assign w_drop     = w_flip & w_full & ~w_pop;

    // Two-flop synchronizer; idle (open) level is all ones.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
        end else begin
            r_row_s1 <= row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state     <= DRIVE;
            r_div       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_raw       <= '0;
            r_col_out   <= '1;
            r_key_state <= '0;
            r_overflow  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // Registered so the drive is released while in reset.
            r_col_out <= ~(4'b0001 << w_col_next);
            unique case (r_state)
                DRIVE: begin
                    if (r_div == DW'(SCAN_DIV - 1)) begin
                        r_raw   <= ~r_row_s2;
                        r_div   <= '0;
                        r_row   <= '0;
                        r_state <= UPDATE;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                UPDATE: begin
                    if (w_sample == w_level) begin
                        r_cnt[w_p] <= '0;
                    end else if (w_flip) begin
                        r_cnt[w_p]       <= '0;
                        r_key_state[w_k] <= ~w_level;
                    end else begin
                        r_cnt[w_p] <= w_cnt_next;
                    end
                    if (r_row == 2'd3) begin
                        r_col   <= r_col + 2'd1;
                        r_state <= DRIVE;
                    end
                    r_row <= r_row + 2'd1;
                end
                default: r_state <= DRIVE;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    keypad_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_push  (w_flip),
        .i_din   (w_event),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_dout  (event_data)
    );

    assign col_out     = r_col_out;
    assign event_valid = ~w_empty;
    assign key_state   = r_key_state;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3,
// FIFO_DEPTH=8, 32-cycle frame). A matrix model drives row_in from the
// closed-key mask and col_out; a monitor records every handshake pop.
module tb_keypad_scanner;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic        event_valid;
    logic [7:0]  event_data;
    logic        event_ready;
    logic [15:0] key_state;
    logic        overflow;

    logic [15:0] closed;          // bit p = physical key row*4+col closed
    logic [7:0]  popped [$];
    logic        hold_chk_en;
    logic        r_prev_stall;
    logic [7:0]  r_prev_data;
    int unsigned n_checks;
    int unsigned n_pass;

    always #5 clk_in = ~clk_in;

    assign row_in[0] = ~|(closed[3:0]   & ~col_out);
    assign row_in[1] = ~|(closed[7:4]   & ~col_out);
    assign row_in[2] = ~|(closed[11:8]  & ~col_out);
    assign row_in[3] = ~|(closed[15:12] & ~col_out);

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .col_out     (col_out),
        .row_in      (row_in),
        .event_valid (event_valid),
        .event_data  (event_data),
        .event_ready (event_ready),
        .key_state   (key_state),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk_in);
    endtask

    function automatic logic [7:0] pop_at(input int unsigned i);
        if (i < 32'(popped.size())) return popped[i];
        return 8'hEE;
    endfunction

    task automatic wait_pops(input string tag, input int unsigned n, input int unsigned budget);
        int unsigned i;
        i = 0;
        while (32'(popped.size()) < n && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, 32'(popped.size()) >= n, 1);
    endtask

    // Pop recorder and hold-stability checker, sampled 1 ns after negedge.
    always @(negedge clk_in) begin
        #1;
        if (rst_n_in && event_valid && event_ready) popped.push_back(event_data);
        if (hold_chk_en && r_prev_stall) begin
            check("hold_valid", event_valid, 1);
            check("hold_data", event_data, r_prev_data);
        end
        r_prev_stall = event_valid && !event_ready;
        r_prev_data  = event_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  exp5 [9];
        logic [15:0] ks;
        int unsigned i;
        exp5 = '{8'h81, 8'h82, 8'h83, 8'h8C, 8'h84, 8'h85, 8'h86, 8'h8D, 8'h87};
        n_checks     = 0;
        n_pass       = 0;
        hold_chk_en  = 1'b0;
        r_prev_stall = 1'b0;
        r_prev_data  = 8'hFF;
        closed       = '0;
        event_ready  = 1'b1;
        rst_n_in     = 1'b0;

        // Reset
        tick(5);
        check("rst_col", col_out, 4'b1111);
        check("rst_valid", event_valid, 0);
        check("rst_data", event_data, 8'hFF);
        check("rst_keys", key_state, 0);
        check("rst_ovf", overflow, 0);
        rst_n_in = 1'b1;
        tick(1);
        check("post_rst_col", col_out, 4'b1110);

        // Clean press / release of r0c0 (key 1)
        closed = 16'h0001;
        tick(160);
        check("t2_press_count", popped.size(), 1);
        check("t2_press_data", pop_at(0), 8'h81);
        check("t2_press_keys", key_state, 16'h0002);
        popped.delete();
        closed = 16'h0000;
        wait_pops("t2_release_latency", 1, 104);
        tick(64);
        check("t2_release_count", popped.size(), 1);
        check("t2_release_data", pop_at(0), 8'h01);
        check("t2_release_keys", key_state, 16'h0000);
        popped.delete();

        // Bounce on r2c2 (key 9): two samples only, then a full press
        closed = 16'h0400;
        tick(64);
        closed = 16'h0000;
        tick(64);
        check("t3_bounce_none", popped.size(), 0);
        check("t3_bounce_keys", key_state, 16'h0000);
        closed = 16'h0400;
        tick(64);
        check("t3_cnt_reset", popped.size(), 0);
        wait_pops("t3_press", 1, 48);
        check("t3_press_data", pop_at(0), 8'h89);
        check("t3_press_keys", key_state, 16'h0200);
        popped.delete();
        closed = 16'h0000;
        tick(140);
        check("t3_release_data", pop_at(0), 8'h09);
        popped.delete();

        // Simultaneous r3c1 (key 0) and r0c3 (key C), closed during column 0
        i = 0;
        while (col_out !== 4'b1110 && i < 64) begin
            tick(1);
            i++;
        end
        check("t4_align", col_out, 4'b1110);
        closed = 16'h2008;
        tick(160);
        check("t4_count", popped.size(), 2);
        check("t4_first", pop_at(0), 8'h80);
        check("t4_second", pop_at(1), 8'h8C);
        check("t4_keys", key_state, 16'h1001);
        closed = 16'h0000;
        tick(160);
        check("t4_release_keys", key_state, 16'h0000);
        popped.delete();

        // Backpressure and overflow: nine presses, one at a time
        event_ready = 1'b0;
        hold_chk_en = 1'b1;
        for (int p = 0; p < 9; p++) begin
            if (p == 8) check("t5_ovf_before", overflow, 0);
            closed[p] = 1'b1;
            tick(128);
        end
        check("t5_stall_pops", popped.size(), 0);
        check("t5_valid", event_valid, 1);
        check("t5_head", event_data, 8'h81);
        check("t5_ovf", overflow, 1);
        ks = 16'h30FE;
        check("t5_keys", key_state, ks);
        event_ready = 1'b1;
        tick(12);
        check("t5_drain_count", popped.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5_drain_%0d", k), pop_at(k), exp5[k]);
        end
        check("t5_empty_valid", event_valid, 0);
        check("t5_empty_data", event_data, 8'hFF);
        hold_chk_en = 1'b0;
        closed = 16'h0000;
        tick(160);
        check("t5_release_keys", key_state, 16'h0000);
        check("t5_ovf_sticky", overflow, 1);
        popped.delete();

        // Reset mid-operation with three queued events and key 5 held
        event_ready = 1'b0;
        closed[0] = 1'b1;
        tick(128);
        closed[1] = 1'b1;
        tick(128);
        closed[5] = 1'b1;
        tick(128);
        check("t6_queued", event_valid, 1);
        check("t6_keys", key_state, 16'h0026);
        rst_n_in = 1'b0;
        closed   = 16'h0020;
        tick(2);
        check("t6_rst_valid", event_valid, 0);
        check("t6_rst_data", event_data, 8'hFF);
        check("t6_rst_keys", key_state, 16'h0000);
        check("t6_rst_ovf", overflow, 0);
        rst_n_in    = 1'b1;
        event_ready = 1'b1;
        popped.delete();
        wait_pops("t6_rereport", 1, 120);
        check("t6_rereport_data", pop_at(0), 8'h85);
        tick(64);
        check("t6_count", popped.size(), 1);
        check("t6_keys_after", key_state, 16'h0020);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a physical 4x4 CHIP-8 hex keypad matrix, debounces each key, and emits press/release event bytes.
- Event bytes use the encoding the emulator's keyboard consumer already decodes: bit7 = pressed(1)/released(0), bits3:0 = CHIP-8 key, 8'hFF = idle.
- The block is the producer side of that key-event interface. It replaces the host-side key source for hardware builds and feeds the keyboard state table.

Parameters:
- SCAN_DIV, 4: cycles each column is driven before rows are sampled. Must be >= 3.
- DEBOUNCE_SCANS, 3: consecutive frame samples that must disagree with the stable state before that state flips. Range 1..15.
- FIFO_DEPTH, 8: event FIFO entries. Power of two, >= 2.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  synchronous active-low reset
- col_out  out  4  column drive, active-low, one-hot-zero
- row_in  in  4  row sense, active-low, pulled up, asynchronous
- event_valid  out  1  event byte available
- event_data  out  8  event byte; 8'hFF when event_valid=0
- event_ready  in  1  consumer accepts the byte
- key_state  out  16  debounced level per CHIP-8 key (bit n = key n held)
- overflow  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Reset values (while rst_n_in=0, sampled on clk_in):
  - col_out=4'b1111, event_valid=0, event_data=8'hFF, key_state=0, overflow=0.
  - FIFO empty; all debounce counters 0; column index 0; state DRIVE.
  - Reset asserted mid-operation discards pending events and debounce progress.
- row_in passes through a 2-flop synchronizer; only the synchronized value is used.
- FSM:
  - DRIVE: col_out has bit[col]=0. Stay SCAN_DIV cycles. On the last cycle, latch the synchronized rows into raw[3:0] (inverted, 1 = closed). Go to UPDATE, row=0.
  - UPDATE: one row per cycle, rows 0..3. col_out stays driven.
    - Physical index p = row*4+col; CHIP-8 key k = KEYMAP[p].
    - If raw[row] == key_state[k]: cnt[p] <= 0.
    - Else cnt[p]+1. When it reaches DEBOUNCE_SCANS: key_state[k] toggles, cnt[p] <= 0, and event {toggled level, 3'b000, k} is pushed.
    - After row 3: col <= col+1 (wraps 3->0) and return to DRIVE.
- Frame period = 4*(SCAN_DIV+4) cycles. Each key is evaluated once per frame.
- Push/output timing:
  - At most one push per cycle.
  - key_state updates in the same edge as the push.
  - A pushed event appears on event_valid/event_data the cycle after the UPDATE cycle, including when the FIFO was empty.
- Handshake:
  - Pop on event_valid && event_ready.
  - event_data is held stable while event_valid && !event_ready.
  - event_valid is never retracted without a pop, except by reset.
- FIFO boundaries:
  - Full with no pop: push is dropped, overflow <= 1 (cleared only by reset), and key_state still updates.
  - Full with a pop in the same cycle: push is accepted.
  - Empty: no pop occurs regardless of event_ready.
  - FIFO order is strict (first in, first out).
- Press-to-event latency: DEBOUNCE_SCANS frames worst case, plus 1 cycle.
- Ghosting: multiple closed keys are reported as sampled; no anti-ghost logic.

Decomposition:
- Package chip8_kbd_pkg:
  - KEYMAP[16] physical->CHIP-8: row0 1 2 3 C, row1 4 5 6 D, row2 7 8 9 E, row3 A 0 B F.
  - KEY_IDLE=8'hFF; EV_PRESS_BIT=7.
  - scan_state_t enum {DRIVE, UPDATE}.
  - Event byte pack function.
- Sub-module keypad_event_fifo:
  - Synchronous FIFO with parameters FIFO_DEPTH and width 8.
  - push/full, pop/empty, head data.
  - Outputs 8'hFF when empty.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=8, frame = 32 cycles):
- Reset: hold rst_n_in=0 for 5 cycles, then release -> col_out=1111 during reset and 1110 on the first cycle after; event_data=FF, event_valid=0, key_state=0, overflow=0.
- Clean press/release: close r0c0, hold 5 frames, event_ready=1 -> exactly one 0x81 and key_state[1]=1. Open it -> exactly one 0x01 after <=3 frames+1 cycle, and key_state[1]=0.
- Bounce: close r2c2 for 2 frames, then open -> no event; key_state[9] stays 0; counter reset verified by a later 3-frame press producing 0x89.
- Simultaneous: close r3c1 and r0c3 in the same cycle -> events in scan order, 0x80 then 0x8C; key_state=16'h1001.
- Backpressure/overflow: event_ready=0, generate 9 distinct events -> first 8 held in order with data stable, 9th dropped, overflow=1. Drain with ready=1 -> 8 pops in order, then valid=0 and data=FF.
- Reset mid-operation: 3 events queued and key 5 held -> pulse rst_n_in low -> FIFO empty, key_state=0. Key 5 still closed -> 0x85 re-reported after 3 frames.
